// File: rtl/brid_alloc_pkg.sv
// Shared types for branch-snapshot ID allocation.
// A brid is an 8-bit tag: bit 7 marks a real slot, bits 6:0 hold the slot index
// (upper index bits beyond the configured slot count are always zero).
package brid_alloc_pkg;

  localparam int BRID_W     = 8;
  localparam int BRID_VALID = 7;

  typedef struct packed {
    logic       vld;
    logic [6:0] idx;
  } brid_t;

endpackage

// File: rtl/brid_alloc.sv
// Purpose : allocate snapshot IDs to decoded branches in program order from a circular
//           pool, release them in order at commit, and squash younger IDs on redirect.
// Latency : grants (ready/brid) are combinational from registered state; pointer, live,
//           free_cnt and full updates land on the next clk edge. Commit-freed slots are
//           usable one cycle later.
// Backpressure: decode lanes are accepted as an in-order prefix; the first lane that is
//           invalid or is a branch without a free slot stops acceptance for itself and all
//           higher lanes. Redirect or reset blocks every lane.
// Ports   : clk/rst (sync, active-high); dec_valid/dec_branch -> ready/brid (decode side);
//           com_valid/com_brid (commit release); redir/redir_brid (squash);
//           live/free_cnt/full (registered occupancy status).
module brid_alloc
  import brid_alloc_pkg::*;
#(
  parameter int dwd  = 4,
  parameter int cwd  = 4,
  parameter int brsz = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [dwd-1:0]           dec_valid,
  input  logic [dwd-1:0]           dec_branch,
  output logic [dwd-1:0]           ready,
  output brid_t [dwd-1:0]          brid,
  input  logic [cwd-1:0]           com_valid,
  input  brid_t [cwd-1:0]          com_brid,
  input  logic                     redir,
  input  brid_t                    redir_brid,
  output logic [brsz-1:0]          live,
  output logic [$clog2(brsz):0]    free_cnt,
  output logic                     full
);

  localparam int IW = $clog2(brsz);
  localparam int CW = IW + 1;

  logic [IW-1:0]   r_head;
  logic [IW-1:0]   r_tail;
  logic [CW-1:0]   r_cnt;
  logic [brsz-1:0] r_live;
  logic [CW-1:0]   r_free_cnt;
  logic            r_full;

  // grant scan
  logic [CW-1:0]   w_avail;
  logic [CW-1:0]   w_nalloc;
  logic            w_scan_ok;
  logic [IW-1:0]   w_slot;
  logic [brsz-1:0] w_set_mask;

  // commit release
  logic [CW-1:0]   w_nrel;
  logic [IW-1:0]   w_rel_slot;
  logic [brsz-1:0] w_rel_mask;
  logic            w_rel_ok;

  // next state
  logic [IW-1:0]   w_head_c;
  logic [brsz-1:0] w_live_c;
  logic [CW-1:0]   w_cnt_c;
  logic [IW-1:0]   w_redir_idx;
  logic [IW-1:0]   w_redir_span;
  logic [brsz-1:0] w_keep;
  logic [IW-1:0]   w_tail_n;
  logic [CW-1:0]   w_cnt_n;
  logic [brsz-1:0] w_live_n;

  // Prefix grant. Only slots free at the start of the cycle are offered; slots
  // being released by commit this cycle are deliberately not bypassed.
  always_comb begin
    ready      = '0;
    brid       = '0;
    w_nalloc   = '0;
    w_set_mask = '0;
    w_slot     = '0;
    w_avail    = CW'(brsz) - r_cnt;
    w_scan_ok  = ~(rst | redir);
    for (int i = 0; i < dwd; i++) begin
      w_slot = r_tail + IW'(w_nalloc);
      if (w_scan_ok && dec_valid[i] && (!dec_branch[i] || (w_nalloc < w_avail))) begin
        ready[i] = 1'b1;
        if (dec_branch[i]) begin
          brid[i].vld        = 1'b1;
          brid[i].idx        = 7'(w_slot);
          w_set_mask[w_slot] = 1'b1;
          w_nalloc           = w_nalloc + CW'(1);
        end
      end else begin
        w_scan_ok = 1'b0;
      end
    end
  end

  // Releasing lanes free consecutive slots starting at head, in lane order.
  always_comb begin
    w_nrel     = '0;
    w_rel_mask = '0;
    w_rel_slot = '0;
    w_rel_ok   = 1'b1;
    for (int j = 0; j < cwd; j++) begin
      if (com_valid[j] && com_brid[j].vld) begin
        w_rel_slot             = r_head + IW'(w_nrel);
        w_rel_mask[w_rel_slot] = 1'b1;
        if (com_brid[j].idx != 7'(w_rel_slot)) w_rel_ok = 1'b0;
        w_nrel = w_nrel + CW'(1);
      end
    end
  end

  // Redirect is evaluated against the post-commit head, so the surviving span is
  // head'..redirecting slot inclusive, measured as a modular distance.
  always_comb begin
    w_head_c     = r_head + IW'(w_nrel);
    w_live_c     = r_live & ~w_rel_mask;
    w_cnt_c      = r_cnt - w_nrel;
    w_redir_idx  = redir_brid.idx[IW-1:0];
    w_redir_span = w_redir_idx - w_head_c;
    w_keep       = '0;
    for (int s = 0; s < brsz; s++) begin
      w_keep[s] = (IW'(s) - w_head_c) <= w_redir_span;
    end

    if (redir) begin
      if (redir_brid.vld) begin
        w_tail_n = w_redir_idx + IW'(1);
        w_cnt_n  = {1'b0, w_redir_span} + CW'(1);
        w_live_n = w_live_c & w_keep;
      end else begin
        w_tail_n = w_head_c;
        w_cnt_n  = '0;
        w_live_n = '0;
      end
    end else begin
      w_tail_n = r_tail + IW'(w_nalloc);
      w_cnt_n  = w_cnt_c + w_nalloc;
      w_live_n = w_live_c | w_set_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_live     <= '0;
      r_free_cnt <= CW'(brsz);
      r_full     <= 1'b0;
    end else begin
      r_head     <= w_head_c;
      r_tail     <= w_tail_n;
      r_cnt      <= w_cnt_n;
      r_live     <= w_live_n;
      r_free_cnt <= CW'(brsz) - w_cnt_n;
      r_full     <= (w_cnt_n == CW'(brsz));
    end
  end

  assign live     = r_live;
  assign free_cnt = r_free_cnt;
  assign full     = r_full;

  // Protocol and invariant checks (simulation only).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_cnt <= CW'(brsz));
      assert ($countones(r_live) == int'(r_cnt));
      assert (w_rel_ok);
      if (redir && redir_brid.vld) begin
        assert (w_live_c[w_redir_idx]);
        assert (redir_brid.idx == 7'(w_redir_idx));
      end
    end
  end

endmodule

// File: tb/tb_brid_alloc.sv
module tb_brid_alloc;
  import brid_alloc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dec_valid;
  logic [3:0]  dec_branch;
  logic [3:0]  ready;
  brid_t [3:0] brid;
  logic [3:0]  com_valid;
  brid_t [3:0] com_brid;
  logic        redir;
  brid_t       redir_brid;
  logic [7:0]  live;
  logic [3:0]  free_cnt;
  logic        full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brid_alloc #(.dwd(4), .cwd(4), .brsz(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_branch (dec_branch),
    .ready      (ready),
    .brid       (brid),
    .com_valid  (com_valid),
    .com_brid   (com_brid),
    .redir      (redir),
    .redir_brid (redir_brid),
    .live       (live),
    .free_cnt   (free_cnt),
    .full       (full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    dec_valid  = '0;
    dec_branch = '0;
    com_valid  = '0;
    com_brid   = '0;
    redir      = 1'b0;
    redir_brid = '0;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ordered list of allocated slots plus the next slot to hand out.
  int          q[$];
  int          mhead;
  int          mtail;
  int          nrel, nb, avail, k, rslot;
  logic        ok;
  logic [3:0]  exp_rdy;
  logic [31:0] exp_brid;
  logic [7:0]  exp_live;

  initial begin
    idle();
    // ---------------- reset ----------------
    rst = 1'b1; dec_valid = 4'hF; dec_branch = 4'hF;
    tick(); tick();
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_brid",  32'(brid),  32'h0);
    chk("rst_live",  32'(live),  32'h0);
    chk("rst_free",  32'(free_cnt), 32'd8);
    chk("rst_full",  32'(full),  32'h0);

    // ---------------- mixed lanes from empty ----------------
    rst = 1'b0; dec_valid = 4'hF; dec_branch = 4'b1101; #1;
    chk("d1_ready", 32'(ready), 32'hF);
    chk("d1_brid",  32'(brid),  32'h82810080);
    tick();
    chk("d1_free", 32'(free_cnt), 32'd5);

    // ---------------- fill to 7 then run out ----------------
    dec_branch = 4'hF; #1;
    chk("d2a_brid", 32'(brid), 32'h86858483);
    tick();
    chk("d2a_free", 32'(free_cnt), 32'd1);
    dec_branch = 4'b0101; #1;
    chk("d2_ready", 32'(ready), 32'h3);
    chk("d2_brid",  32'(brid),  32'h00000087);
    tick();
    chk("d2_full", 32'(full), 32'h1);
    chk("d2_free", 32'(free_cnt), 32'd0);

    // ---------------- full: commit frees, no same-cycle bypass ----------------
    dec_valid = 4'b0001; dec_branch = 4'b0001;
    com_valid = 4'b0111; com_brid = 32'h00828180; #1;
    chk("d3_ready_full", 32'(ready), 32'h0);
    tick();
    com_valid = 4'b0001; com_brid = 32'h00000083;
    chk("d3_free", 32'(free_cnt), 32'd3);
    #1;
    chk("d3_ready", 32'(ready), 32'h1);
    chk("d3_brid",  32'(brid),  32'h00000080);
    tick();
    chk("d3_live", 32'(live), 32'hF1);
    chk("d3_free2", 32'(free_cnt), 32'd3);

    // ---------------- reset beats redirect and commit ----------------
    rst = 1'b1; redir = 1'b1; redir_brid = 8'h85;
    com_valid = 4'b0001; com_brid = 32'h00000084; #1;
    chk("d6_ready", 32'(ready), 32'h0);
    chk("d6_brid",  32'(brid),  32'h0);
    tick();
    chk("d6_live", 32'(live), 32'h0);
    chk("d6_free", 32'(free_cnt), 32'd8);
    chk("d6_full", 32'(full), 32'h0);

    // ---------------- redirect keeps older slots ----------------
    idle(); dec_valid = 4'hF; dec_branch = 4'hF; #1;
    chk("d4_brid0", 32'(brid), 32'h83828180);
    tick();
    dec_valid = 4'b0111; dec_branch = 4'b0111; #1;
    chk("d4_brid1", 32'(brid), 32'h00868584);
    tick();
    dec_valid = '0; dec_branch = '0;
    com_valid = 4'b0011; com_brid = 32'h00008180;
    tick();
    chk("d4_pre_free", 32'(free_cnt), 32'd3);
    chk("d4_pre_live", 32'(live), 32'h7C);
    com_valid = '0; redir = 1'b1; redir_brid = 8'h84;
    dec_valid = 4'b0001; dec_branch = 4'b0001; #1;
    chk("d4_ready_redir", 32'(ready), 32'h0);
    tick();
    redir = 1'b0; redir_brid = '0;
    chk("d4_live", 32'(live), 32'h1C);
    chk("d4_free", 32'(free_cnt), 32'd5);
    #1;
    chk("d4_tail_brid", 32'(brid), 32'h00000085);
    tick();

    // ---------------- commit plus squash-all ----------------
    com_valid = 4'b0001; com_brid = 32'h00000082;
    redir = 1'b1; redir_brid = 8'h00; #1;
    chk("d5_ready", 32'(ready), 32'h0);
    tick();
    com_valid = '0; com_brid = '0; redir = 1'b0;
    chk("d5_live", 32'(live), 32'h0);
    chk("d5_free", 32'(free_cnt), 32'd8);
    #1;
    chk("d5_head_brid", 32'(brid), 32'h00000083);
    tick();

    // ---------------- randomized run against the slot-list model ----------------
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete(); mhead = 0; mtail = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_live = '0;
      foreach (q[i]) exp_live[q[i]] = 1'b1;
      chk("r_live", 32'(live), 32'(exp_live));
      chk("r_free", 32'(free_cnt), 32'(8 - q.size()));
      chk("r_full", 32'(full), 32'(q.size() == 8));

      dec_valid  = 4'($urandom);
      dec_branch = 4'($urandom);
      nrel = 0;
      for (int i = 0; i < 4; i++) begin
        com_valid[i] = 1'($urandom);
        if (com_valid[i] && nrel < q.size() && ($urandom % 2 == 0)) begin
          com_brid[i] = 8'(8'h80 | q[nrel]);
          nrel++;
        end else if (com_valid[i]) begin
          com_brid[i] = 8'($urandom % 128);
        end else begin
          com_brid[i] = 8'($urandom);
        end
      end
      redir = ($urandom % 8 == 0);
      k = -1;
      rslot = 0;
      if (redir) begin
        if ((q.size() - nrel) > 0 && ($urandom % 4 != 0)) begin
          k = nrel + int'($urandom % (q.size() - nrel));
          rslot = q[k];
          redir_brid = 8'(8'h80 | rslot);
        end else begin
          redir_brid = 8'($urandom % 128);
        end
      end else begin
        redir_brid = 8'($urandom);
      end

      avail = 8 - q.size();
      nb = 0; ok = !redir; exp_rdy = '0; exp_brid = '0;
      for (int i = 0; i < 4; i++) begin
        if (ok && dec_valid[i] && (!dec_branch[i] || nb < avail)) begin
          exp_rdy[i] = 1'b1;
          if (dec_branch[i]) begin
            exp_brid[i*8 +: 8] = 8'(8'h80 | ((mtail + nb) % 8));
            nb++;
          end
        end else begin
          ok = 1'b0;
        end
      end
      #1;
      chk("r_ready", 32'(ready), 32'(exp_rdy));
      chk("r_brid",  32'(brid),  exp_brid);

      for (int i = 0; i < nrel; i++) void'(q.pop_front());
      mhead = (mhead + nrel) % 8;
      if (redir) begin
        if (k >= 0) begin
          while (q.size() > k - nrel + 1) void'(q.pop_back());
          mtail = (rslot + 1) % 8;
        end else begin
          q.delete();
          mtail = mhead;
        end
      end else begin
        for (int b = 0; b < nb; b++) q.push_back((mtail + b) % 8);
        mtail = (mtail + nb) % 8;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
